lcd_text_feeder: RTL and testbench

Upstream stage of the LCD1602 character driver. It holds a 2×16 character screen buffer written by the host. After a power-up wait it emits the HD44780 init command sequence, then refreshes both display lines continuously. It presents a stream of 9-bit {RS, DATA} words over a valid/ready handshake, and the driver consumes one word per LCD enable cycle.

---
 rtl/lcd_text_feeder.sv | 159 +++++++++++++++
 tb/tb_lcd_text_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_feeder.sv
// Feeds an HD44780 character driver: power-up wait, init command sequence, then an
// endless refresh of a host-writable 2x16 screen buffer as {RS, DATA} words over valid/ready.
module lcd_text_feeder #(
  parameter int PWRUP_CYCLES = 400000,
  parameter int CLEAR_GAP    = 40000
) (
  input  logic       lcd_clk_in,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       clear_req,
  output logic       busy,
  output logic [8:0] out_word,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       init_done
);

  localparam int MAX_WAIT = (PWRUP_CYCLES > CLEAR_GAP) ? PWRUP_CYCLES : CLEAR_GAP;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_GAP - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_CLRWAIT,
    S_ADDR,
    S_CHAR
  } state_t;

  logic [7:0]       r_buf [0:31];
  logic             r_busy;
  logic [4:0]       r_clr_addr;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_init_idx;
  logic [3:0]       r_col;
  logic             r_line;
  logic [8:0]       r_word;
  logic             r_valid;
  logic             r_init_done;

  logic             w_xfer;
  logic [4:0]       w_next_addr;

  assign w_xfer      = r_valid & out_ready;
  assign w_next_addr = {r_line, r_col + 4'd1};

  assign busy      = r_busy;
  assign out_word  = r_word;
  assign out_valid = r_valid;
  assign init_done = r_init_done;

  function automatic logic [8:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    init_word = 9'h038;
      2'd1:    init_word = 9'h00C;
      2'd2:    init_word = 9'h006;
      default: init_word = 9'h001;
    endcase
  endfunction

  // A running clear owns the buffer write port; a clear request beats a same-cycle host write.
  always_ff @(posedge lcd_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
      r_busy     <= 1'b0;
      r_clr_addr <= 5'd0;
    end else if (r_busy) begin
      r_buf[r_clr_addr] <= 8'h20;
      r_clr_addr        <= r_clr_addr + 5'd1;
      if (r_clr_addr == 5'd31) r_busy <= 1'b0;
    end else if (clear_req) begin
      r_busy     <= 1'b1;
      r_clr_addr <= 5'd0;
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_char;
    end
  end

  // r_word always holds the word being presented; the next one is loaded on the transfer edge.
  always_ff @(posedge lcd_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_init_idx  <= 2'd0;
      r_col       <= 4'd0;
      r_line      <= 1'b0;
      r_word      <= 9'h000;
      r_valid     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_PWRUP: begin
          if (r_cnt == PWRUP_LAST) begin
            r_cnt      <= '0;
            r_init_idx <= 2'd0;
            r_word     <= init_word(2'd0);
            r_valid    <= 1'b1;
            r_state    <= S_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_INIT: begin
          if (w_xfer) begin
            if (r_init_idx == 2'd3) begin
              r_valid <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_CLRWAIT;
            end else begin
              r_init_idx <= r_init_idx + 2'd1;
              r_word     <= init_word(r_init_idx + 2'd1);
            end
          end
        end
        S_CLRWAIT: begin
          if (r_cnt == CLEAR_LAST) begin
            r_cnt       <= '0;
            r_line      <= 1'b0;
            r_word      <= 9'h080;
            r_valid     <= 1'b1;
            r_init_done <= 1'b1;
            r_state     <= S_ADDR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ADDR: begin
          if (w_xfer) begin
            r_col   <= 4'd0;
            r_word  <= {1'b1, r_buf[{r_line, 4'd0}]};
            r_state <= S_CHAR;
          end
        end
        S_CHAR: begin
          if (w_xfer) begin
            if (r_col == 4'd15) begin
              r_line  <= ~r_line;
              r_word  <= r_line ? 9'h080 : 9'h0C0;
              r_state <= S_ADDR;
            end else begin
              r_col  <= r_col + 4'd1;
              r_word <= {1'b1, r_buf[w_next_addr]};
            end
          end
        end
        default: begin
          r_state <= S_PWRUP;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Scoreboard bench for lcd_text_feeder: expected words are queued as stimulus is applied
// and popped against every accepted DUT word; a mirror buffer supplies expected characters.
module tb_lcd_text_feeder;

  localparam int PWRUP = 10;
  localparam int GAP   = 5;

  logic       clk = 1'b0;
  logic       rstN;
  logic       wrEn;
  logic [4:0] wrAddr;
  logic [7:0] wrChar;
  logic       clearReq;
  logic       busy;
  logic [8:0] outWord;
  logic       outValid;
  logic       outReady;
  logic       initDone;

  int         checks = 0;
  int         failures = 0;
  int         lastWait = 0;
  logic [8:0] expQ[$];
  logic [7:0] mBuf[32];

  always #5 clk = ~clk;

  lcd_text_feeder #(.PWRUP_CYCLES(PWRUP), .CLEAR_GAP(GAP)) dut (
    .lcd_clk_in(clk),
    .rst_n(rstN),
    .wr_en(wrEn),
    .wr_addr(wrAddr),
    .wr_char(wrChar),
    .clear_req(clearReq),
    .busy(busy),
    .out_word(outWord),
    .out_valid(outValid),
    .out_ready(outReady),
    .init_done(initDone)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic fillMirror();
    for (int i = 0; i < 32; i++) mBuf[i] = 8'h20;
  endtask

  task automatic pushAddr(input int line);
    expQ.push_back(line != 0 ? 9'h0C0 : 9'h080);
  endtask

  task automatic pushLine(input int line, input int fromCol, input int toCol);
    for (int c = fromCol; c <= toCol; c++) expQ.push_back({1'b1, mBuf[line*16 + c]});
  endtask

  // All helpers below start and end on a falling edge.
  task automatic popCompare(input string tag);
    logic [8:0] expWord;
    bit hit;
    hit = 1'b0;
    expWord = expQ.pop_front();
    for (int w = 0; w < 200 && !hit; w++) begin
      if (outValid && outReady) begin
        checkOutput(tag, int'(outWord), int'(expWord));
        lastWait = w;
        hit = 1'b1;
      end
      @(negedge clk);
    end
    if (!hit) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic drain(input string tag, output int waitSum);
    waitSum = 0;
    while (expQ.size() > 0) begin
      popCompare(tag);
      waitSum += lastWait;
    end
  endtask

  task automatic countLow(output int n);
    n = 0;
    while (!outValid && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic syncWord(input logic [8:0] w);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (outValid && outReady && outWord == w) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("sync", int'(found), 1);
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [7:0] ch);
    wrEn = 1'b1;
    wrAddr = addr;
    wrChar = ch;
    @(negedge clk);
    wrEn = 1'b0;
    mBuf[addr] = ch;
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    outReady = 1'b1;
    wrEn = 1'b0;
    clearReq = 1'b0;
    #1;
    checkOutput("rst_valid", int'(outValid), 0);
    checkOutput("rst_word", int'(outWord), 0);
    checkOutput("rst_init_done", int'(initDone), 0);
    checkOutput("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    fillMirror();
  endtask

  task automatic runInit();
    int n;
    int ws;
    countLow(n);
    checkOutput("pwrup_low_cycles", n, PWRUP);
    checkOutput("init_done_early", int'(initDone), 0);
    expQ.push_back(9'h038);
    expQ.push_back(9'h00C);
    expQ.push_back(9'h006);
    expQ.push_back(9'h001);
    drain("init_word", ws);
    checkOutput("init_back_to_back", ws, 0);
    countLow(n);
    checkOutput("clear_gap_cycles", n, GAP);
    checkOutput("init_done", int'(initDone), 1);
    pushAddr(0);
    drain("first_addr", ws);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int ws;
    logic [8:0] held;
    rstN = 1'b0;
    wrEn = 1'b0;
    wrAddr = 5'd0;
    wrChar = 8'h00;
    clearReq = 1'b0;
    outReady = 1'b1;
    @(negedge clk);

    $display("[TB] power-up and init");
    resetDut();
    runInit();

    $display("[TB] refresh content");
    applyStimulus(5'd0, "H");
    applyStimulus(5'd1, "E");
    applyStimulus(5'd2, "L");
    applyStimulus(5'd3, "L");
    applyStimulus(5'd4, "O");
    applyStimulus(5'd16, "O");
    applyStimulus(5'd17, "K");
    syncWord(9'h080);
    pushAddr(0); pushLine(0, 0, 15); pushAddr(1); pushLine(1, 0, 15); pushAddr(0);
    drain("pass_hello", ws);

    $display("[TB] clear collision");
    clearReq = 1'b1;
    wrEn = 1'b1;
    wrAddr = 5'd3;
    wrChar = "X";
    checkOutput("busy_before_clear", int'(busy), 0);
    @(negedge clk);
    clearReq = 1'b0;
    wrAddr = 5'd5;
    wrChar = "Q";
    n = 0;
    if (busy) n++;
    @(negedge clk);
    wrEn = 1'b0;
    while (busy && n < 100) begin
      n++;
      if (n == 20) begin
        wrEn = 1'b1;
        wrAddr = 5'd0;
        wrChar = "W";
      end else begin
        wrEn = 1'b0;
      end
      @(negedge clk);
    end
    wrEn = 1'b0;
    checkOutput("busy_cycles", n, 32);
    fillMirror();
    syncWord(9'h080);
    pushAddr(0); pushLine(0, 0, 15); pushAddr(1); pushLine(1, 0, 15);
    drain("pass_cleared", ws);

    $display("[TB] write during presentation");
    applyStimulus(5'd4, "A");
    syncWord(9'h080);
    pushAddr(0); pushLine(0, 0, 1);
    drain("pre_hold", ws);
    held = {1'b1, mBuf[2]};
    outReady = 1'b0;
    wrEn = 1'b1;
    wrAddr = 5'd2;
    wrChar = "Z";
    @(negedge clk);
    wrEn = 1'b0;
    mBuf[2] = "Z";
    checkOutput("held_word", int'(outWord), int'(held));
    checkOutput("held_valid", int'(outValid), 1);
    @(negedge clk);
    checkOutput("held_word_later", int'(outWord), int'(held));
    outReady = 1'b1;
    expQ.push_back(held);
    pushLine(0, 3, 15); pushAddr(1); pushLine(1, 0, 15); pushAddr(0); pushLine(0, 0, 4);
    drain("pass_z", ws);

    $display("[TB] reset mid-refresh");
    syncWord(9'h080);
    pushAddr(0); pushLine(0, 0, 0);
    drain("pre_reset", ws);
    resetDut();
    runInit();
    pushLine(0, 0, 15); pushAddr(1); pushLine(1, 0, 15);
    drain("pass_after_reset", ws);

    $display("[TB] backpressure");
    resetDut();
    countLow(n);
    checkOutput("bp_pwrup_low_cycles", n, PWRUP);
    expQ.push_back(9'h038);
    popCompare("bp_first");
    outReady = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checkOutput("bp_word_stable", int'(outWord), 9'h00C);
      checkOutput("bp_valid_stable", int'(outValid), 1);
      @(negedge clk);
    end
    checkOutput("bp_word_final", int'(outWord), 9'h00C);
    outReady = 1'b1;
    expQ.push_back(9'h00C);
    popCompare("bp_release");
    checkOutput("bp_release_wait", lastWait, 0);
    checkOutput("bp_next_word", int'(outWord), 9'h006);
    checkOutput("bp_next_valid", int'(outValid), 1);
    expQ.push_back(9'h006);
    expQ.push_back(9'h001);
    drain("bp_tail", ws);
    countLow(n);
    checkOutput("bp_clear_gap", n, GAP);
    pushAddr(0);
    drain("bp_first_addr", ws);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
